// File: rtl/throw_pkg.sv
// Shared types and defaults for the throw-power controller.
// Used by the charger top and its tick divider.
package throw_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    CHARGE  = 2'd1,
    HOLD    = 2'd2,
    LOCKOUT = 2'd3
  } throw_state_t;

  localparam int DEFAULT_TICK_CYCLES = 2820000;
  localparam int DEFAULT_PWR_W       = 4;

endpackage

// File: rtl/throw_charger_tick_div.sv
// Power-step tick divider for the throw charger.
// Emits one tick per TICK_CYCLES enabled cycles.
module tick_div
  import throw_pkg::*;
#(
  parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
  input  logic clk60MHz,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // tick ignores clr so the FSM can feed clr from its next state
  assign tick = en && (cnt == LAST);

  // count enabled cycles, wrapping at LAST; clr wins over en
  always_ff @(posedge clk60MHz) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/throw_charger.sv
// Throw-power controller: ramps power while left is held,
// latches it on release and flags the throw until end_throw.
module throw_charger
  import throw_pkg::*;
#(
  parameter int PWR_W       = DEFAULT_PWR_W,
  parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES,
  parameter bit PINGPONG    = 1'b0,
  parameter int MIN_POWER   = 1
) (
  input  logic             clk60MHz,
  input  logic             rst,
  input  logic             left,
  input  logic             right,
  input  logic             turn,
  input  logic             current_player,
  input  logic             end_throw,
  output logic [PWR_W-1:0] power,
  output logic             throw_flag,
  output logic             charging
);

  localparam int PW1 = PWR_W + 1;
  localparam logic [PW1-1:0] PMAX = PW1'((1 << PWR_W) - 1);
  localparam logic [PW1-1:0] PMIN = PW1'(MIN_POWER);

  throw_state_t   state, state_nxt;
  logic [PW1-1:0] pwr, pwr_nxt, pwr_step;
  logic           dir_dn, dir_nxt, dir_step;
  logic           flag_nxt, chg_nxt;
  logic           tick, my_turn;

  assign my_turn = (turn == current_player);
  assign power   = pwr[PWR_W-1:0];

  tick_div #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .en       (state == CHARGE),
    .clr      (state_nxt != CHARGE),
    .tick     (tick)
  );

  // next power value and direction for one ramp step
  always_comb begin
    pwr_step = pwr;
    dir_step = dir_dn;
    if (!PINGPONG) begin
      if (pwr < PMAX) pwr_step = pwr + PW1'(1);
    end else if (!dir_dn) begin
      pwr_step = pwr + PW1'(1);
      if (pwr_step == PMAX) dir_step = 1'b1;
    end else begin
      pwr_step = pwr - PW1'(1);
      if (pwr_step == '0) dir_step = 1'b0;
    end
  end

  // next-state and registered-output decode
  always_comb begin
    state_nxt = state;
    pwr_nxt   = '0;
    dir_nxt   = 1'b0;
    flag_nxt  = 1'b0;
    chg_nxt   = 1'b0;
    unique case (state)
      WAIT: begin
        pwr_nxt  = '0;
        dir_nxt  = 1'b0;
        flag_nxt = 1'b0;
        if (left && my_turn && !right) begin
          state_nxt = CHARGE;
          chg_nxt   = 1'b1;
        end else begin
          state_nxt = WAIT;
          chg_nxt   = 1'b0;
        end
      end
      CHARGE: begin
        if (right || !my_turn) begin
          state_nxt = LOCKOUT;
          pwr_nxt   = '0;
          dir_nxt   = 1'b0;
          flag_nxt  = 1'b0;
          chg_nxt   = 1'b0;
        end else if (!left) begin
          dir_nxt = 1'b0;
          chg_nxt = 1'b0;
          if (pwr >= PMIN) begin
            state_nxt = HOLD;
            pwr_nxt   = pwr;
            flag_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT;
            pwr_nxt   = '0;
            flag_nxt  = 1'b0;
          end
        end else begin
          state_nxt = CHARGE;
          pwr_nxt   = tick ? pwr_step : pwr;
          dir_nxt   = tick ? dir_step : dir_dn;
          flag_nxt  = 1'b0;
          chg_nxt   = 1'b1;
        end
      end
      HOLD: begin
        dir_nxt = 1'b0;
        chg_nxt = 1'b0;
        if (end_throw) begin
          state_nxt = LOCKOUT;
          pwr_nxt   = '0;
          flag_nxt  = 1'b0;
        end else begin
          state_nxt = HOLD;
          pwr_nxt   = pwr;
          flag_nxt  = 1'b1;
        end
      end
      LOCKOUT: begin
        pwr_nxt   = '0;
        dir_nxt   = 1'b0;
        flag_nxt  = 1'b0;
        chg_nxt   = 1'b0;
        state_nxt = (!left && !right) ? WAIT : LOCKOUT;
      end
      default: begin
        state_nxt = WAIT;
        pwr_nxt   = '0;
        dir_nxt   = 1'b0;
        flag_nxt  = 1'b0;
        chg_nxt   = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state      <= WAIT;
      pwr        <= '0;
      dir_dn     <= 1'b0;
      throw_flag <= 1'b0;
      charging   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pwr        <= pwr_nxt;
      dir_dn     <= dir_nxt;
      throw_flag <= flag_nxt;
      charging   <= chg_nxt;
    end
  end

endmodule

// File: tb/tb_throw_charger.sv
// Bench for throw_charger: saturating and ping-pong instances
// driven in parallel and compared against a duration-based model.
module tb_throw_charger;

  localparam int TC   = 4;
  localparam int PMX  = 7;
  localparam int MINP = 1;

  logic clk = 1'b0;
  logic rst, left, right, turn, cp, et;
  logic [2:0] pw_s, pw_p;
  logic tf_s, tf_p, ch_s, ch_p;

  int tests = 0;
  int fails = 0;
  int mode [2];
  int n    [2];
  int lat  [2];

  always #5 clk = ~clk;

  throw_charger #(
    .PWR_W(3), .TICK_CYCLES(TC), .PINGPONG(1'b0), .MIN_POWER(MINP)
  ) dut_s (
    .clk60MHz(clk), .rst(rst), .left(left), .right(right),
    .turn(turn), .current_player(cp), .end_throw(et),
    .power(pw_s), .throw_flag(tf_s), .charging(ch_s)
  );

  throw_charger #(
    .PWR_W(3), .TICK_CYCLES(TC), .PINGPONG(1'b1), .MIN_POWER(MINP)
  ) dut_p (
    .clk60MHz(clk), .rst(rst), .left(left), .right(right),
    .turn(turn), .current_player(cp), .end_throw(et),
    .power(pw_p), .throw_flag(tf_p), .charging(ch_p)
  );

  // power after k completed ticks of charging
  function automatic int fval(int k, int pp);
    int m;
    if (pp == 0) return (k > PMX) ? PMX : k;
    m = k % (2 * PMX);
    return (m <= PMX) ? m : (2 * PMX - m);
  endfunction

  // mode: 0 idle, 1 charging, 2 throwing, 3 locked out
  task automatic model();
    int p;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mode[i] = 0; n[i] = 0; lat[i] = 0;
      end else begin
        case (mode[i])
          0: if (left && turn == cp && !right) begin
               mode[i] = 1; n[i] = 0;
             end
          1: if (right || turn != cp) mode[i] = 3;
             else if (!left) begin
               p = fval(n[i] / TC, i);
               if (p >= MINP) begin mode[i] = 2; lat[i] = p; end
               else mode[i] = 0;
             end else n[i]++;
          2: if (et) mode[i] = 3;
          default: if (!left && !right) mode[i] = 0;
        endcase
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(string tag);
    int ep;
    model();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      ep = (mode[i] == 1) ? fval(n[i] / TC, i) :
           (mode[i] == 2) ? lat[i] : 0;
      chk({tag, i ? "/pp.power" : "/sat.power"},
          32'(i ? pw_p : pw_s), 32'(ep));
      chk({tag, i ? "/pp.flag" : "/sat.flag"},
          32'(i ? tf_p : tf_s), 32'(mode[i] == 2));
      chk({tag, i ? "/pp.chg" : "/sat.chg"},
          32'(i ? ch_p : ch_s), 32'(mode[i] == 1));
    end
  endtask

  task automatic drive(logic l, logic r, logic t, logic e,
                       int cnt, string tag);
    left = l; right = r; turn = t; et = e;
    repeat (cnt) step(tag);
  endtask

  initial begin
    cp = 1'b1; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; n[i] = 0; lat[i] = 0;
    end
    drive(0, 0, 1, 0, 1, "reset");
    chk("reset_power", 32'(pw_s), 0);
    rst = 1'b0;
    drive(0, 0, 1, 0, 2, "idle");

    drive(1, 0, 1, 0, 40, "sat_ramp");
    chk("sat_stuck", 32'(pw_s), 7);
    drive(0, 0, 1, 0, 1, "sat_release");
    chk("sat_hold_pw", 32'(pw_s), 7);
    chk("sat_hold_tf", 32'(tf_s), 1);
    drive(0, 0, 1, 1, 1, "sat_end");
    chk("sat_end_pw", 32'(pw_s), 0);
    chk("sat_end_tf", 32'(tf_s), 0);
    drive(0, 0, 1, 0, 2, "idle");

    drive(1, 0, 1, 0, 79, "pp_ramp");
    drive(0, 0, 1, 0, 1, "pp_release");
    chk("pp_hold_pw", 32'(pw_p), 5);
    chk("pp_hold_tf", 32'(tf_p), 1);
    drive(0, 0, 1, 1, 1, "pp_end");
    drive(0, 0, 1, 0, 2, "idle");

    drive(1, 0, 1, 0, 2, "min_press");
    drive(0, 0, 1, 0, 2, "min_release");
    chk("min_no_flag", 32'(tf_s), 0);
    drive(1, 0, 1, 0, 1, "min_repress");
    chk("min_rearm", 32'(ch_s), 1);
    drive(0, 0, 1, 0, 2, "idle");

    drive(1, 0, 1, 0, 13, "cancel_ramp");
    drive(1, 1, 1, 0, 1, "cancel");
    chk("cancel_pw", 32'(pw_s), 0);
    drive(1, 0, 1, 0, 3, "cancel_lock");
    chk("cancel_lock_chg", 32'(ch_s), 0);
    drive(0, 1, 1, 0, 2, "cancel_right");
    drive(0, 0, 1, 0, 1, "cancel_rearm");
    drive(1, 0, 1, 0, 6, "turn_ramp");
    drive(1, 0, 0, 0, 1, "turn_loss");
    drive(1, 0, 1, 0, 3, "turn_lock");
    chk("turn_lock_chg", 32'(ch_p), 0);
    drive(0, 0, 1, 0, 2, "idle");

    drive(1, 0, 1, 0, 12, "tick_ramp");
    drive(0, 0, 1, 0, 1, "tick_release");
    chk("tick_latch", 32'(pw_s), 2);
    drive(1, 0, 1, 0, 3, "hold_ignore");
    drive(1, 0, 1, 1, 1, "end_held");
    drive(1, 0, 1, 0, 4, "held_lock");
    chk("held_no_chg", 32'(ch_s), 0);
    drive(0, 0, 1, 0, 1, "held_drop");
    drive(1, 0, 1, 0, 2, "held_repress");
    chk("held_rearm", 32'(ch_s), 1);
    drive(0, 0, 1, 0, 2, "idle");

    drive(1, 0, 1, 0, 20, "rst_ramp");
    drive(0, 0, 1, 0, 2, "rst_hold");
    rst = 1'b1;
    drive(0, 0, 1, 0, 1, "rst_mid");
    chk("rst_mid_tf", 32'(tf_s), 0);
    rst = 1'b0;
    drive(0, 0, 1, 0, 1, "rst_wait");
    drive(1, 0, 0, 0, 5, "wrong_player");
    chk("wrong_player_chg", 32'(ch_s), 0);
    drive(0, 0, 1, 0, 1, "idle");

    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 8 == 0) left = ~left;
      right = ($urandom % 25 == 0);
      turn  = ($urandom % 30 == 0) ? ~cp : cp;
      et    = ($urandom % 10 == 0);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
